cbus_mem_responder: RTL
=======================

# cbus_mem_responder

Memory-side responder for the simplified burst cache bus (`cbus_req_t` / `cbus_resp_t`). It is the far end of the cache's refill and writeback port: it accepts one burst transaction at a time, waits a programmable access latency, then serves one beat per cycle from an internal 64-bit-word memory array. It is used as the simulation and FPGA backing store behind the I/D caches and as the golden responder for cache verification.

## Interface
- `MEM_WORDS`, 4096: number of 64-bit words in the array; a power of two.
- `LATENCY`, 2: idle cycles between request acceptance and the first beat; 0 is legal.
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `creq` in `cbus_req_t` (151): request fields `valid`, `is_write`, `size`, `addr`, `strobe`, `data`, `len`, `burst`.
- `cresp` out `cbus_resp_t` (66): response fields `ready` (beat completes this cycle), `last` (final beat), `data` (read data).

## Operation
- **States:** IDLE, WAIT, BEAT.
- **Reset:** state is IDLE; `cresp.ready`, `cresp.last` and `cresp.data` are all 0. Array contents are not reset. A reset in mid-burst aborts the burst immediately. Beats already written stay in the array.
- **IDLE:** when `creq.valid`=1 at a rising edge, latch `is_write`, `size`, `addr`, `len` and `burst`, and clear the beat counter.
  - Go to WAIT if `LATENCY`>0, otherwise to BEAT.
- **WAIT:** a down-counter loaded with `LATENCY`-1 decrements each cycle. Go to BEAT when it reaches 0.
- **BEAT:**
  - `cresp.ready`=1 every cycle.
  - `cresp.last`=1 when the beat counter equals the latched `len`.
  - On a read beat, `cresp.data` = array word at index `cur_addr[log2(MEM_WORDS)+2:3]`, full 64 bits, unshifted.
  - On a write beat, each byte i of that word with `creq.strobe[i]`=1 takes `creq.data[8i+7:8i]`. `creq.data` and `creq.strobe` are sampled live each beat, because the master advances them after each `ready`.
  - After the last beat, go to IDLE.
- **Outside BEAT:** `cresp` is all-zero. Read data is also 0 on write beats.
- **Master obligation:** `creq.valid` and the latched fields stay stable until the edge that samples `last`. The responder ignores `creq.valid` outside IDLE.
- **Address advance per beat:** `step` = 1 << `size` bytes.
  - INCR (and RESERVED, which is treated as INCR): `cur_addr += step`.
  - FIXED: `cur_addr` is unchanged.
  - WRAP: let `bound` = (`len`+1)·`step`. Then `cur_addr` = (`cur_addr` & ~(`bound`-1)) | ((`cur_addr`+`step`) & (`bound`-1)). `len`+1 is a power of two by protocol.
- **Address range:** address bits above the array range are ignored, so indices wrap modulo `MEM_WORDS`. Byte-within-word bits [2:0] never shift data; strobe does the byte placement.
- **Sub-word sizes:** consecutive beats may hit the same word. Each beat re-reads the array, so a write beat is visible to any later beat in the same or a later burst.

## Timing
- Request accepted at edge E0.
- Beat k (k = 0..`len`) occupies the cycle that starts at edge E0 + `LATENCY` + k.
- Total occupancy is `LATENCY` + `len` + 1 cycles after acceptance.
- Beats are back-to-back with no bubbles.
- Back-to-back transactions: the earliest next acceptance is the edge after the edge that completes the last beat (one IDLE cycle minimum).
- Read data is combinational from the array plus the registered address, so it is valid in the same cycle as `ready`. A write takes effect at the end of its beat cycle.
- `last` is never asserted without `ready`. A `len`=0 request yields exactly one beat, with `ready` and `last` both set.

## Test plan
- **Reset mid-burst:** assert `resetn`=0 during beat 2 of a 4-beat read. `cresp` goes to 0 immediately, the block is in IDLE after release, and the next request is served normally.
- **INCR write then read:** INCR, MSIZE8, `len`=MLEN4, `addr`=0x80000000, `LATENCY`=2, write data 0x11..0x44 with strobe 0xFF.
  - The read-back burst shows `ready` at cycles E0+2..E0+5, `last` only at E0+5, and data 0x11, 0x22, 0x33, 0x44.
- **WRAP read:** WRAP, MSIZE8, `len`=MLEN4, `addr`=0x80000010 over words 0..3 = A, B, C, D. Beats return C, D, A, B; `last` is on B.
- **Strobe merge:** word 0x1122334455667788 at 0x80000008, then a single write (`len`=MLEN1) with `data`=0xAABBCCDD00000000 and `strobe`=0xF0.
  - Read-back = 0xAABBCCDD55667788.
- **FIXED burst:** FIXED write, `len`=MLEN2, two beats with data 0x5 then 0x6 to the same address. Read-back = 0x6.
- **Zero latency, back-to-back:** `LATENCY`=0, `len`=0 read.
  - `ready` and `last` are both set in the cycle after acceptance.
  - A second request held valid is accepted one IDLE cycle later.
  - Index wrap: an address of 0x80000000 + 8·`MEM_WORDS` aliases word 0.

Source files
------------

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder
//   Memory-side responder for the simplified burst cache bus. Accepts one
//   burst at a time, waits LATENCY idle cycles, then serves one beat per
//   cycle from an internal array of MEM_WORDS 64-bit words.
//
// Ports
//   clk     in   clock, all state updates on the rising edge
//   resetn  in   asynchronous active-low reset
//   creq    in   request bundle, MSB first:
//                  [150] valid  [149] is_write  [148:146] size
//                  [145:82] addr  [81:74] strobe  [73:10] data
//                  [9:2] len  [1:0] burst (0 FIXED, 1 INCR, 2 WRAP, 3 RESERVED)
//   cresp   out  response bundle, MSB first:
//                  [65] ready  [64] last  [63:0] read data
module cbus_mem_responder #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter int unsigned LATENCY   = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [150:0] creq,
  output logic [65:0]  cresp
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] WAIT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT
  } state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  // Request fields
  logic        w_req_valid;
  logic        w_req_write;
  logic [2:0]  w_req_size;
  logic [63:0] w_req_addr;
  logic [7:0]  w_req_strobe;
  logic [63:0] w_req_data;
  logic [7:0]  w_req_len;
  logic [1:0]  w_req_burst;

  assign w_req_valid  = creq[150];
  assign w_req_write  = creq[149];
  assign w_req_size   = creq[148:146];
  assign w_req_addr   = creq[145:82];
  assign w_req_strobe = creq[81:74];
  assign w_req_data   = creq[73:10];
  assign w_req_len    = creq[9:2];
  assign w_req_burst  = creq[1:0];

  // State and latched transaction
  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_is_write;
  logic [2:0]         r_size;
  logic [63:0]        r_addr;
  logic [7:0]         r_len;
  burst_e             r_burst;
  logic [7:0]         r_beat;
  logic [CNT_W-1:0]   r_wait;

  logic [63:0]        r_mem [MEM_WORDS];

  logic               w_beat;
  logic               w_last;
  logic               w_wr_en;
  logic [IDX_W-1:0]   w_idx;
  logic [63:0]        w_rdata;
  logic [63:0]        w_step;
  logic [63:0]        w_wrap_mask;
  logic [63:0]        w_addr_nxt;

  assign w_beat  = (r_state == ST_BEAT);
  assign w_last  = w_beat && (r_beat == r_len);
  assign w_wr_en = w_beat && r_is_write;
  // High address bits are dropped so the index wraps modulo MEM_WORDS;
  // byte-in-word bits never move data, strobe places bytes instead.
  assign w_idx   = r_addr[IDX_W+2:3];

  // Address advance
  assign w_step      = 64'd1 << r_size;
  assign w_wrap_mask = ((64'(r_len) + 64'd1) << r_size) - 64'd1;

  always_comb begin
    w_addr_nxt = r_addr + w_step;
    unique case (r_burst)
      BURST_FIXED: w_addr_nxt = r_addr;
      BURST_WRAP:  w_addr_nxt = (r_addr & ~w_wrap_mask) | ((r_addr + w_step) & w_wrap_mask);
      default:     w_addr_nxt = r_addr + w_step;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_valid) begin
          if (LATENCY > 0) w_state_nxt = ST_WAIT;
          else             w_state_nxt = ST_BEAT;
        end
      end
      ST_WAIT: begin
        if (r_wait == '0) w_state_nxt = ST_BEAT;
      end
      ST_BEAT: begin
        if (w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Transaction datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_is_write <= 1'b0;
      r_size     <= '0;
      r_addr     <= '0;
      r_len      <= '0;
      r_burst    <= BURST_FIXED;
      r_beat     <= '0;
      r_wait     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_req_valid) begin
            r_is_write <= w_req_write;
            r_size     <= w_req_size;
            r_addr     <= w_req_addr;
            r_len      <= w_req_len;
            r_burst    <= burst_e'(w_req_burst);
            r_beat     <= '0;
            r_wait     <= WAIT_INIT;
          end
        end
        ST_WAIT: begin
          if (r_wait != '0) r_wait <= r_wait - 1'b1;
        end
        ST_BEAT: begin
          r_beat <= r_beat + 8'd1;
          r_addr <= w_addr_nxt;
        end
        default: ;
      endcase
    end
  end

  // Array write: data and strobe are taken live from the bus each beat
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (w_req_strobe[i]) r_mem[w_idx][8*i +: 8] <= w_req_data[8*i +: 8];
      end
    end
  end

  // Read data is combinational so it lines up with ready
  always_comb begin
    w_rdata = '0;
    if (w_beat && !r_is_write) w_rdata = r_mem[w_idx];
  end

  assign cresp = {w_beat, w_last, w_rdata};

endmodule
